// File: rtl/demux1_2.sv
// Registered 1-to-2 data router: one valid/ready input stream is steered by S1 into one of two
// independent 2-entry FIFOs, each draining to its own consumer. Per-port pop counters for debug.
module demux1_2 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CW    = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] D,
   input  logic             S1,
   input  logic             IV,
   output logic             IR,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic             V1,
   output logic             V2,
   input  logic             R1,
   input  logic             R2,
   output logic [CW-1:0]    CNT1,
   output logic [CW-1:0]    CNT2
);

   // Index 0 is output port 1, index 1 is output port 2.
   logic [1:0][1:0]       fill_q, fill_d;
   logic [1:0][WIDTH-1:0] head_q, head_d;
   logic [1:0][WIDTH-1:0] tail_q, tail_d;
   logic [1:0][CW-1:0]    cnt_q, cnt_d;
   logic [1:0]            full, valid, push, pop;

   // Handshake decode; IR looks only at registered fill so no R->IR path exists.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         full[k]  = (fill_q[k] == 2'd2);
         valid[k] = (fill_q[k] != 2'd0);
      end
      IR      = RST_N && (S1 ? !full[1] : !full[0]);
      push[0] = IV && IR && !S1;
      push[1] = IV && IR && S1;
      pop[0]  = valid[0] && R1;
      pop[1]  = valid[1] && R2;
   end

   // Per-port FIFO next state: head/tail pair with a 0..2 fill level.
   always_comb begin
      fill_d = fill_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      for (int k = 0; k < 2; k++) begin
         unique case (fill_q[k])
            2'd0: begin
               if (push[k]) begin
                  head_d[k] = D;
                  fill_d[k] = 2'd1;
               end
            end
            2'd1: begin
               if (push[k] && pop[k]) begin
                  // Old head leaves, new word becomes head; level unchanged.
                  head_d[k] = D;
               end else if (push[k]) begin
                  tail_d[k] = D;
                  fill_d[k] = 2'd2;
               end else if (pop[k]) begin
                  fill_d[k] = 2'd0;
               end
            end
            default: begin
               // Full: push is blocked by IR, only a pop can happen.
               if (pop[k]) begin
                  head_d[k] = tail_q[k];
                  fill_d[k] = 2'd1;
               end
            end
         endcase
         cnt_d[k] = cnt_q[k] + CW'(pop[k]);
      end
   end

   // State registers; async reset drops all buffered words at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fill_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         fill_q <= fill_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Outputs come from state only; data is zeroed while a port is empty.
   always_comb begin
      V1   = valid[0];
      V2   = valid[1];
      O1   = valid[0] ? head_q[0] : '0;
      O2   = valid[1] ? head_q[1] : '0;
      CNT1 = cnt_q[0];
      CNT2 = cnt_q[1];
   end

endmodule

// File: tb/tb_demux1_2.sv
// Directed bench for demux1_2: inputs change on the falling edge, outputs checked there too.
module tb_demux1_2;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CW    = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] d;
   logic             s1;
   logic             iv;
   logic             ir;
   logic [WIDTH-1:0] o1, o2;
   logic             v1, v2;
   logic             r1, r2;
   logic [CW-1:0]    cnt1, cnt2;

   int vectors;
   int miscompares;

   demux1_2 #(.WIDTH(WIDTH), .CW(CW)) dut (
      .CLK(clk), .RST_N(rst_n), .D(d), .S1(s1), .IV(iv), .IR(ir),
      .O1(o1), .O2(o2), .V1(v1), .V2(v2), .R1(r1), .R2(r2),
      .CNT1(cnt1), .CNT2(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; d = '0; s1 = 1'b0; iv = 1'b0; r1 = 1'b0; r2 = 1'b0;
      #3;
      vectors++;
      if (ir !== 1'b0) begin miscompares++; $display("FAIL reset_ir got %b want 0", ir); end
      vectors++;
      if ({v1, v2} !== 2'b00) begin miscompares++; $display("FAIL reset_v got %b want 00", {v1, v2}); end
      vectors++;
      if ({o1, o2} !== 32'h0) begin miscompares++; $display("FAIL reset_o got %h want 0", {o1, o2}); end
      vectors++;
      if ({cnt1, cnt2} !== 16'h0) begin miscompares++; $display("FAIL reset_cnt got %h want 0", {cnt1, cnt2}); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ir !== 1'b1) begin miscompares++; $display("FAIL release_ir got %b want 1", ir); end
   endtask

   task automatic test_route1();
      @(negedge clk);
      d = 16'd77; s1 = 1'b0; iv = 1'b1; r1 = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (o1 !== 16'd77 || v1 !== 1'b1) begin
         miscompares++; $display("FAIL route1_out got o1=%0d v1=%b want 77/1", o1, v1);
      end
      vectors++;
      if (o2 !== 16'd0 || v2 !== 1'b0) begin
         miscompares++; $display("FAIL route1_other got o2=%0d v2=%b want 0/0", o2, v2);
      end
      @(negedge clk);
      vectors++;
      if (cnt1 !== 8'd1 || v1 !== 1'b0) begin
         miscompares++; $display("FAIL route1_pop got cnt1=%0d v1=%b want 1/0", cnt1, v1);
      end
   endtask

   task automatic test_route2();
      @(negedge clk);
      d = 16'd99; s1 = 1'b1; iv = 1'b1; r2 = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (o2 !== 16'd99 || v2 !== 1'b1 || v1 !== 1'b0) begin
         miscompares++; $display("FAIL route2_out got o2=%0d v2=%b v1=%b want 99/1/0", o2, v2, v1);
      end
      @(negedge clk);
      vectors++;
      if (cnt2 !== 8'd1 || cnt1 !== 8'd1) begin
         miscompares++; $display("FAIL route2_pop got cnt2=%0d cnt1=%0d want 1/1", cnt2, cnt1);
      end
      r2 = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      r1 = 1'b0; s1 = 1'b0; iv = 1'b1; d = 16'd1;
      #1;
      vectors++;
      if (ir !== 1'b1) begin miscompares++; $display("FAIL bp_ir1 got %b want 1", ir); end
      @(negedge clk);
      d = 16'd2;
      #1;
      vectors++;
      if (ir !== 1'b1) begin miscompares++; $display("FAIL bp_ir2 got %b want 1", ir); end
      @(negedge clk);
      d = 16'd3;
      #1;
      vectors++;
      if (ir !== 1'b0 || o1 !== 16'd1) begin
         miscompares++; $display("FAIL bp_full got ir=%b o1=%0d want 0/1", ir, o1);
      end
      @(negedge clk);
      vectors++;
      if (o1 !== 16'd1 || v1 !== 1'b1 || ir !== 1'b0) begin
         miscompares++; $display("FAIL bp_hold got o1=%0d v1=%b ir=%b want 1/1/0", o1, v1, ir);
      end
      // Keep offering 3; it goes in once the first pop frees a slot.
      r1 = 1'b1;
      @(negedge clk);
      vectors++;
      if (o1 !== 16'd2) begin miscompares++; $display("FAIL bp_seq2 got %0d want 2", o1); end
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (o1 !== 16'd3 || v1 !== 1'b1) begin
         miscompares++; $display("FAIL bp_seq3 got o1=%0d v1=%b want 3/1", o1, v1);
      end
      @(negedge clk);
      // One earlier pop on port 1 plus three here.
      vectors++;
      if (cnt1 !== 8'd4 || v1 !== 1'b0) begin
         miscompares++; $display("FAIL bp_cnt got cnt1=%0d v1=%b want 4/0", cnt1, v1);
      end
   endtask

   task automatic test_independence();
      @(negedge clk);
      r2 = 1'b0; s1 = 1'b1; iv = 1'b1; d = 16'hA1;
      @(negedge clk);
      d = 16'hA2;
      r1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            if (o1 !== 16'(10 + i - 1) || v1 !== 1'b1) begin
               miscompares++;
               $display("FAIL indep_o1_%0d got o1=%0d v1=%b want %0d/1", i, o1, v1, 10 + i - 1);
            end
         end
         if (i == 5) begin
            s1 = 1'b1; d = 16'hBAD; iv = 1'b1;
            #1;
            vectors++;
            if (ir !== 1'b0) begin miscompares++; $display("FAIL indep_stall_ir got %b want 0", ir); end
            @(negedge clk);
            vectors++;
            if (v1 !== 1'b0) begin miscompares++; $display("FAIL indep_drain got v1=%b want 0", v1); end
         end
         s1 = 1'b0; d = 16'(10 + i); iv = 1'b1;
         #1;
         vectors++;
         if (ir !== 1'b1) begin miscompares++; $display("FAIL indep_ir_%0d got %b want 1", i, ir); end
      end
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (o1 !== 16'd19 || v1 !== 1'b1) begin
         miscompares++; $display("FAIL indep_last got o1=%0d v1=%b want 19/1", o1, v1);
      end
      @(negedge clk);
      vectors++;
      if (cnt1 !== 8'd14 || v1 !== 1'b0) begin
         miscompares++; $display("FAIL indep_cnt1 got cnt1=%0d v1=%b want 14/0", cnt1, v1);
      end
      vectors++;
      if (o2 !== 16'hA1 || v2 !== 1'b1 || cnt2 !== 8'd1) begin
         miscompares++; $display("FAIL indep_p2 got o2=%h v2=%b cnt2=%0d want a1/1/1", o2, v2, cnt2);
      end
      r2 = 1'b1;
      @(negedge clk);
      vectors++;
      if (o2 !== 16'hA2) begin miscompares++; $display("FAIL indep_p2_seq got %h want a2", o2); end
      @(negedge clk);
      r2 = 1'b0;
      vectors++;
      if (cnt2 !== 8'd3 || v2 !== 1'b0) begin
         miscompares++; $display("FAIL indep_p2_cnt got cnt2=%0d v2=%b want 3/0", cnt2, v2);
      end
   endtask

   task automatic test_push_pop_count1();
      @(negedge clk);
      r1 = 1'b0; s1 = 1'b0; iv = 1'b1; d = 16'd4;
      @(negedge clk);
      vectors++;
      if (o1 !== 16'd4 || v1 !== 1'b1) begin
         miscompares++; $display("FAIL pp_head got o1=%0d v1=%b want 4/1", o1, v1);
      end
      r1 = 1'b1; d = 16'd5;
      #1;
      vectors++;
      if (ir !== 1'b1) begin miscompares++; $display("FAIL pp_ir got %b want 1", ir); end
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (o1 !== 16'd5 || v1 !== 1'b1 || cnt1 !== 8'd15) begin
         miscompares++; $display("FAIL pp_swap got o1=%0d v1=%b cnt1=%0d want 5/1/15", o1, v1, cnt1);
      end
      @(negedge clk);
      vectors++;
      if (v1 !== 1'b0 || cnt1 !== 8'd16) begin
         miscompares++; $display("FAIL pp_empty got v1=%b cnt1=%0d want 0/16", v1, cnt1);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      r1 = 1'b0; r2 = 1'b0; s1 = 1'b0; iv = 1'b1; d = 16'd7;
      @(negedge clk);
      s1 = 1'b1; d = 16'd8;
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if ({v1, v2} !== 2'b11) begin miscompares++; $display("FAIL mid_fill got %b want 11", {v1, v2}); end
      // Assert reset in the low phase, well away from any rising edge.
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({v1, v2, ir} !== 3'b000 || {o1, o2} !== 32'h0 || {cnt1, cnt2} !== 16'h0) begin
         miscompares++;
         $display("FAIL mid_reset got v=%b ir=%b o=%h cnt=%h want all 0", {v1, v2}, ir, {o1, o2},
                  {cnt1, cnt2});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ir !== 1'b1) begin miscompares++; $display("FAIL mid_release_ir got %b want 1", ir); end
   endtask

   task automatic test_back_to_back_wrap();
      int stalls;
      stalls = 0;
      r2 = 1'b1; s1 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         d = 16'(i); iv = 1'b1;
         #1;
         if (ir !== 1'b1) stalls++;
      end
      vectors++;
      if (stalls !== 0) begin miscompares++; $display("FAIL wrap_stalls got %0d want 0", stalls); end
      @(negedge clk);
      iv = 1'b0;
      vectors++;
      if (cnt2 !== 8'd255 || o2 !== 16'd255) begin
         miscompares++; $display("FAIL wrap_255 got cnt2=%0d o2=%0d want 255/255", cnt2, o2);
      end
      @(negedge clk);
      vectors++;
      if (cnt2 !== 8'd0 || v2 !== 1'b0) begin
         miscompares++; $display("FAIL wrap_zero got cnt2=%0d v2=%b want 0/0", cnt2, v2);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_route1();
      test_route2();
      test_backpressure();
      test_independence();
      test_push_pop_count1();
      test_reset_mid();
      test_back_to_back_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
